// File: rtl/serial_add_unit_pkg.sv
// Shared types and helpers for the bit-serial adder unit.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Reference full-adder equations, used to cross-check the fa_bit slice.
    function automatic logic fa_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    function automatic logic fa_carry(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/serial_add_unit_if.sv
// Operand and result handshakes of the serial adder, bundled as one interface.
interface serial_add_unit_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    // Producer/consumer side of the unit.
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    // The adder unit itself.
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/serial_add_unit_fa_bit.sv
// Single-bit full adder; the same slice is used by the tile-level adder.
module fa_bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);
    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_a & i_ci) | (i_b & i_ci);
endmodule

// File: rtl/serial_add_unit.sv
// Bit-serial adder: operands stream LSB-first through one full-adder slice
// with a registered carry; result is presented over a valid/ready handshake.
module serial_add_unit
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    serial_add_unit_if.slave io
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             w_s;
    logic             w_co;
    logic             w_last;

    fa_bit u_fa (
        .i_a  (r_a_sh[0]),
        .i_b  (r_b_sh[0]),
        .i_ci (r_carry),
        .o_s  (w_s),
        .o_co (w_co)
    );

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next state and handshake outputs; in_ready is masked by reset directly.
    always_comb begin
        w_next       = r_state;
        io.in_ready  = 1'b0;
        io.out_valid = 1'b0;
        io.busy      = 1'b0;
        case (r_state)
            IDLE: begin
                io.in_ready = !rst;
                if (io.in_valid) w_next = RUN;
            end
            RUN: begin
                io.busy = 1'b1;
                if (w_last) w_next = DONE;
            end
            DONE: begin
                io.busy      = 1'b1;
                io.out_valid = 1'b1;
                if (io.out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand load, bit-serial shift/accumulate, and result capture on the last bit.
    // The counter holds at WIDTH-1 on the final bit so it never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (io.in_valid) begin
                    r_a_sh  <= io.a;
                    r_b_sh  <= io.b;
                    r_carry <= io.cin;
                    r_cnt   <= '0;
                end
                RUN: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_sum_sh <= {w_s, r_sum_sh[WIDTH-1:1]};
                    r_carry  <= w_co;
                    if (w_last) begin
                        r_sum  <= {w_s, r_sum_sh[WIDTH-1:1]};
                        r_cout <= w_co;
                        r_ovf  <= r_carry ^ w_co;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io.sum  = r_sum;
    assign io.cout = r_cout;
    assign io.ovf  = r_ovf;

    // The slice must match the reference full-adder equations while shifting.
    a_fa_slice: assert property (@(posedge clk) disable iff (rst)
        (r_state == RUN) |-> (w_s == fa_sum(r_a_sh[0], r_b_sh[0], r_carry)) &&
                             (w_co == fa_carry(r_a_sh[0], r_b_sh[0], r_carry)));

endmodule

// File: doc/serial_add_unit.md
Name: serial_add_unit

Overview:
- Bit-serial adder stage that feeds the team's single-bit full-adder cell.
- Accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake.
- Streams the operands LSB-first through one full-adder slice, with a registered carry.
- Returns the WIDTH-bit sum, carry-out and signed-overflow flag over a second valid/ready handshake.
- Area-cheap alternative to a ripple adder for the TinyTapeout tile; the wrapper maps ui_in/uio_in to operands.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  unit can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  a+b+cin, modulo 2^WIDTH.
- cout  out  1  carry out of MSB.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (asynchronous assert, synchronous deassert by the system):
  - state=IDLE.
  - Shift registers, sum, cout, ovf, bit counter and carry all 0.
  - out_valid=0, busy=0.
  - in_ready is forced 0 while rst is high.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready at an edge: load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, go RUN.
  - RUN: in_ready=0. Each edge: s=a_sh[0]^b_sh[0]^carry; carry<=majority(a_sh[0],b_sh[0],carry). a_sh and b_sh shift right; sum_sh shifts right with s inserted at bit WIDTH-1; cnt<=cnt+1.
    - When cnt==WIDTH-1: also capture msb_cin<=carry (value before update) and go DONE.
  - DONE: out_valid=1; sum=sum_sh, cout=carry, ovf=msb_cin^carry. On out_valid&out_ready at an edge: go IDLE.
- Latency: acceptance at edge T gives out_valid high after edge T+WIDTH.
  - Minimum initiation interval is WIDTH+2 cycles: a same-cycle accept in DONE is not allowed.
- Back-pressure: in DONE with out_ready low, sum/cout/ovf/out_valid hold indefinitely and stay stable.
- in_valid during RUN or DONE is ignored; operand inputs are not sampled.
- The handshake is sampled only at clock edges; a/b/cin may change freely outside the acceptance edge.
- sum/cout/ovf are driven from registers only (no combinational path from inputs).
  - Their values are meaningful only while out_valid=1.
  - They hold the last result in IDLE.
- Reset mid-operation (RUN or DONE): immediate return to IDLE; the partial/pending result is discarded; out_valid drops asynchronously.
- cnt width is $clog2(WIDTH); the counter is never allowed to wrap past WIDTH-1.
- All-ones plus carry: cout=1 and sum wraps to 0. No saturation.

Decomposition:
- Package serial_add_pkg:
  - state enum {IDLE, RUN, DONE} (2-bit encoding).
  - DEFAULT_WIDTH=8.
  - fa_sum and fa_carry helper functions for use in assertions.
- Sub-module fa_bit: purely combinational 1-bit full adder (a, b, ci -> s, co), instantiated once in the RUN datapath.
  - It is the slice shared with the tile-level full-adder design.
- Top block holds the FSM, counter, shift registers and output registers.

Test Plan:
- WIDTH=8; a=8'h0F, b=8'h01, cin=0 -> sum=8'h10, cout=0, ovf=0. out_valid rises exactly 8 cycles after the accept edge.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0. a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1, ovf=0.
- a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1. a=8'h80, b=8'h80 -> sum=8'h00, cout=1, ovf=1.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and sum stable throughout. in_valid pulses in RUN/DONE are ignored. in_ready returns the cycle after the out handshake.
- Assert rst when cnt=3 in RUN -> out_valid=0, busy=0, state IDLE immediately. After release, a new op 8'h12+8'h34 -> sum=8'h46.
- Random soak: 1000 ops with random valid/ready gaps, checked against a+b+cin reference, WIDTH=8 and WIDTH=2.
